// File: rtl/video_pkg.sv
// Shared BT.656 timing-reference definitions, used by the decoder and the
// matching generator.
package video_pkg;

    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;

    // Bit positions inside the XY status word; bits 3..0 carry the protection bits.
    localparam int XY_BIT_ONE = 7;
    localparam int XY_BIT_F   = 6;
    localparam int XY_BIT_V   = 5;
    localparam int XY_BIT_H   = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_FF  = 3'd1,
        S_00A = 3'd2,
        S_00B = 3'd3,
        S_XY  = 3'd4
    } sync_state_e;

    typedef enum logic [1:0] {
        PH_CB = 2'd0,
        PH_Y0 = 2'd1,
        PH_CR = 2'd2,
        PH_Y1 = 2'd3
    } byte_phase_e;

    // Protection bits {P3, P2, P1, P0} for a given F/V/H combination.
    function automatic logic [3:0] xy_parity(input logic f, input logic v, input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/bt656_xy_check.sv
// Combinational decode of a BT.656 XY status word: F/V/H flags plus a
// validity flag covering the fixed-one bit and the protection bits.
module bt656_xy_check
    import video_pkg::*;
(
    input  logic [7:0] xy,
    output logic       f,
    output logic       v,
    output logic       h,
    output logic       ok
);

    assign f  = xy[XY_BIT_F];
    assign v  = xy[XY_BIT_V];
    assign h  = xy[XY_BIT_H];
    assign ok = xy[XY_BIT_ONE] && (xy[3:0] == xy_parity(f, v, h));

endmodule

// File: rtl/bt656_decoder.sv
// BT.656 byte-stream decoder: finds FF 00 00 XY timing references, tracks
// F/V/H and line/pixel counts, and demultiplexes Cb/Y/Cr/Y into pixels.
module bt656_decoder #(
    parameter int ACTIVE_PIX = 720,
    parameter int LINE_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_en,
    input  logic [7:0]        din,
    output logic [7:0]        y,
    output logic [7:0]        cb,
    output logic [7:0]        cr,
    output logic              pix_valid,
    output logic              f,
    output logic              v,
    output logic              h,
    output logic              sav,
    output logic              eav,
    output logic              frame_start,
    output logic              code_err,
    output logic [LINE_W-1:0] line_cnt,
    output logic [10:0]       pix_cnt
);
    import video_pkg::*;

    localparam logic [10:0]       PIX_LIMIT = 11'(ACTIVE_PIX);
    localparam logic [LINE_W-1:0] LINE_MAX  = {LINE_W{1'b1}};

    sync_state_e       state_q, state_d;
    byte_phase_e       phase_q, phase_d;
    logic              capture_q, capture_d;
    logic [7:0]        cb_hold_q, cb_hold_d, y0_hold_q, y0_hold_d, cr_hold_q, cr_hold_d;
    logic [7:0]        y_q, y_d, cb_q, cb_d, cr_q, cr_d;
    logic              pix_valid_q, pix_valid_d;
    logic              f_q, f_d, v_q, v_d, h_q, h_d;
    logic              sav_q, sav_d, eav_q, eav_d, frame_start_q, frame_start_d, code_err_q, code_err_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [10:0]       pix_cnt_q, pix_cnt_d;
    logic              xy_f, xy_v, xy_h, xy_ok;

    bt656_xy_check u_xy_check (
        .xy (din),
        .f  (xy_f),
        .v  (xy_v),
        .h  (xy_h),
        .ok (xy_ok)
    );

    always_comb begin
        // NOTE: every _d gets a default before any branch so no latch is inferred.
        state_d       = state_q;
        phase_d       = phase_q;
        capture_d     = capture_q;
        cb_hold_d     = cb_hold_q;
        y0_hold_d     = y0_hold_q;
        cr_hold_d     = cr_hold_q;
        y_d           = y_q;
        cb_d          = cb_q;
        cr_d          = cr_q;
        f_d           = f_q;
        v_d           = v_q;
        h_d           = h_q;
        line_cnt_d    = line_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        pix_valid_d   = 1'b0;
        sav_d         = 1'b0;
        eav_d         = 1'b0;
        frame_start_d = 1'b0;
        code_err_d    = 1'b0;

        if (din_en) begin
            case (state_q)
                IDLE, S_XY: state_d = (din == TRS_FF) ? S_FF : IDLE;
                S_FF:       state_d = (din == TRS_00) ? S_00A : (din == TRS_FF) ? S_FF : IDLE;
                S_00A:      state_d = (din == TRS_00) ? S_00B : (din == TRS_FF) ? S_FF : IDLE;
                S_00B:      state_d = S_XY;
                default:    state_d = IDLE;
            endcase

            // A 0xFF can only be the start of a timing reference, never video data.
            if (capture_q) begin
                if (din == TRS_FF) begin
                    capture_d = 1'b0;
                end else begin
                    phase_d = byte_phase_e'(phase_q + 2'd1);
                    case (phase_q)
                        PH_CB: cb_hold_d = din;
                        PH_Y0: y0_hold_d = din;
                        PH_CR: begin
                            cr_hold_d   = din;
                            y_d         = y0_hold_q;
                            cb_d        = cb_hold_q;
                            cr_d        = din;
                            pix_valid_d = 1'b1;
                        end
                        default: begin
                            y_d         = din;
                            cb_d        = cb_hold_q;
                            cr_d        = cr_hold_q;
                            pix_valid_d = 1'b1;
                        end
                    endcase
                    if (pix_valid_d) begin
                        pix_cnt_d = pix_cnt_q + 11'd1;
                        if (pix_cnt_d == PIX_LIMIT) capture_d = 1'b0;
                    end
                end
            end

            if (state_q == S_00B) begin
                if (!xy_ok) begin
                    code_err_d = 1'b1;
                end else begin
                    f_d = xy_f;
                    v_d = xy_v;
                    h_d = xy_h;
                    if (xy_h) begin
                        eav_d     = 1'b1;
                        pix_cnt_d = '0;
                        if (f_q && !xy_f) begin
                            frame_start_d = 1'b1;
                            line_cnt_d    = '0;
                        end else if (line_cnt_q != LINE_MAX) begin
                            line_cnt_d = line_cnt_q + 1'b1;
                        end
                    end else begin
                        sav_d = 1'b1;
                        if (!xy_v) begin
                            capture_d = 1'b1;
                            phase_d   = PH_CB;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            phase_q       <= PH_CB;
            capture_q     <= 1'b0;
            cb_hold_q     <= '0;
            y0_hold_q     <= '0;
            cr_hold_q     <= '0;
            y_q           <= '0;
            cb_q          <= '0;
            cr_q          <= '0;
            pix_valid_q   <= 1'b0;
            f_q           <= 1'b0;
            v_q           <= 1'b1;
            h_q           <= 1'b1;
            sav_q         <= 1'b0;
            eav_q         <= 1'b0;
            frame_start_q <= 1'b0;
            code_err_q    <= 1'b0;
            line_cnt_q    <= '0;
            pix_cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            phase_q       <= phase_d;
            capture_q     <= capture_d;
            cb_hold_q     <= cb_hold_d;
            y0_hold_q     <= y0_hold_d;
            cr_hold_q     <= cr_hold_d;
            y_q           <= y_d;
            cb_q          <= cb_d;
            cr_q          <= cr_d;
            pix_valid_q   <= pix_valid_d;
            f_q           <= f_d;
            v_q           <= v_d;
            h_q           <= h_d;
            sav_q         <= sav_d;
            eav_q         <= eav_d;
            frame_start_q <= frame_start_d;
            code_err_q    <= code_err_d;
            line_cnt_q    <= line_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
        end
    end

    assign y           = y_q;
    assign cb          = cb_q;
    assign cr          = cr_q;
    assign pix_valid   = pix_valid_q;
    assign f           = f_q;
    assign v           = v_q;
    assign h           = h_q;
    assign sav         = sav_q;
    assign eav         = eav_q;
    assign frame_start = frame_start_q;
    assign code_err    = code_err_q;
    assign line_cnt    = line_cnt_q;
    assign pix_cnt     = pix_cnt_q;

endmodule

// File: tb/tb_bt656_decoder.sv
// Directed testbench for bt656_decoder: timing references, parity errors,
// full-line capture, frame start, din_en gaps and mid-line reset.
module tb_bt656_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_en;
    logic [7:0] din;
    logic [7:0] y, cb, cr;
    logic       pix_valid, f, v, h, sav, eav, frame_start, code_err;
    logic [9:0] line_cnt;
    logic [10:0] pix_cnt;

    int checks = 0;
    int passed = 0;
    int n_pv, n_sav, n_eav, n_err, n_fs;

    bt656_decoder #(.ACTIVE_PIX(720), .LINE_W(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .din_en      (din_en),
        .din         (din),
        .y           (y),
        .cb          (cb),
        .cr          (cr),
        .pix_valid   (pix_valid),
        .f           (f),
        .v           (v),
        .h           (h),
        .sav         (sav),
        .eav         (eav),
        .frame_start (frame_start),
        .code_err    (code_err),
        .line_cnt    (line_cnt),
        .pix_cnt     (pix_cnt)
    );

    always #5 clk = ~clk;

    task automatic clear_counts();
        n_pv = 0; n_sav = 0; n_eav = 0; n_err = 0; n_fs = 0;
    endtask

    // Advance one clock and sample registered outputs 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        n_pv  += int'(pix_valid);
        n_sav += int'(sav);
        n_eav += int'(eav);
        n_err += int'(code_err);
        n_fs  += int'(frame_start);
    endtask

    task automatic send(input logic [7:0] b);
        din    = b;
        din_en = 1'b1;
        tick();
        din_en = 1'b0;
    endtask

    task automatic gap();
        din    = 8'hFF;
        din_en = 1'b0;
        tick();
    endtask

    task automatic send_trs(input logic [7:0] xy);
        send(8'hFF);
        send(8'h00);
        send(8'h00);
        send(xy);
    endtask

    task automatic send_group(input logic [7:0] b_cb, input logic [7:0] b_y0,
                              input logic [7:0] b_cr, input logic [7:0] b_y1);
        send(b_cb);
        send(b_y0);
        send(b_cr);
        send(b_y1);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        din_en = 1'b0;
        din    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({y, cb, cr} !== 24'h0) $display("FAIL reset_pix: got %h expected %h", {y, cb, cr}, 24'h0); else passed++;
        checks++; if ({f, v, h} !== 3'b011) $display("FAIL reset_fvh: got %b expected %b", {f, v, h}, 3'b011); else passed++;
        checks++; if ({pix_valid, sav, eav, frame_start, code_err} !== 5'b0) $display("FAIL reset_strobes: got %b expected %b", {pix_valid, sav, eav, frame_start, code_err}, 5'b0); else passed++;
        checks++; if (line_cnt !== 10'd0 || pix_cnt !== 11'd0) $display("FAIL reset_cnts: got %0d/%0d expected 0/0", line_cnt, pix_cnt); else passed++;
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_line();
        send_trs(8'h9D);
        checks++; if ({eav, sav} !== 2'b10) $display("FAIL basic_eav: got eav/sav %b expected %b", {eav, sav}, 2'b10); else passed++;
        checks++; if ({f, v, h} !== 3'b001) $display("FAIL basic_eav_fvh: got %b expected %b", {f, v, h}, 3'b001); else passed++;
        checks++; if (line_cnt !== 10'd1) $display("FAIL basic_line_cnt: got %0d expected 1", line_cnt); else passed++;
        send(8'hFF);
        checks++; if (eav !== 1'b0) $display("FAIL basic_eav_one_cycle: got %b expected 0", eav); else passed++;
        send(8'h00);
        send(8'h00);
        send(8'h80);
        checks++; if ({eav, sav} !== 2'b01) $display("FAIL basic_sav: got eav/sav %b expected %b", {eav, sav}, 2'b01); else passed++;
        checks++; if ({f, v, h} !== 3'b000) $display("FAIL basic_sav_fvh: got %b expected %b", {f, v, h}, 3'b000); else passed++;
        send(8'h80);
        send(8'h10);
        checks++; if (pix_valid !== 1'b0) $display("FAIL basic_no_early_pix: got %b expected 0", pix_valid); else passed++;
        send(8'h80);
        checks++; if ({pix_valid, y, cb, cr} !== {1'b1, 24'h108080}) $display("FAIL basic_pix_a: got %b %h expected 1 108080", pix_valid, {y, cb, cr}); else passed++;
        send(8'h20);
        checks++; if ({pix_valid, y, cb, cr} !== {1'b1, 24'h208080}) $display("FAIL basic_pix_b: got %b %h expected 1 208080", pix_valid, {y, cb, cr}); else passed++;
        checks++; if (pix_cnt !== 11'd2) $display("FAIL basic_pix_cnt: got %0d expected 2", pix_cnt); else passed++;
    endtask

    task automatic test_code_err();
        clear_counts();
        send(8'h80);
        send(8'h30);
        send(8'hFF);
        checks++; if (n_pv !== 0 || pix_cnt !== 11'd2) $display("FAIL ff_ends_capture: got %0d pix, pix_cnt %0d expected 0, 2", n_pv, pix_cnt); else passed++;
        send(8'h00);
        send(8'h00);
        send(8'h9C);
        checks++; if ({code_err, sav, eav} !== 3'b100) $display("FAIL err_strobes: got %b expected %b", {code_err, sav, eav}, 3'b100); else passed++;
        checks++; if ({f, v, h} !== 3'b000) $display("FAIL err_fvh_held: got %b expected %b", {f, v, h}, 3'b000); else passed++;
        checks++; if (line_cnt !== 10'd1 || pix_cnt !== 11'd2) $display("FAIL err_cnts_held: got %0d/%0d expected 1/2", line_cnt, pix_cnt); else passed++;
    endtask

    task automatic test_full_line();
        int bad = 0;
        logic [7:0] e_cb, e_y0, e_cr, e_y1;
        send_trs(8'h9D);
        checks++; if (line_cnt !== 10'd2 || pix_cnt !== 11'd0) $display("FAIL line_eav_cnts: got %0d/%0d expected 2/0", line_cnt, pix_cnt); else passed++;
        send_trs(8'h80);
        clear_counts();
        for (int i = 0; i < 360; i++) begin
            e_cb = 8'h40 + 8'(i % 32);
            e_y0 = 8'h10 + 8'(i % 64);
            e_cr = 8'hA0 + 8'(i % 32);
            e_y1 = 8'h60 + 8'(i % 64);
            send(e_cb);
            send(e_y0);
            send(e_cr);
            if (pix_valid !== 1'b1 || {y, cb, cr} !== {e_y0, e_cb, e_cr}) bad++;
            send(e_y1);
            if (pix_valid !== 1'b1 || {y, cb, cr} !== {e_y1, e_cb, e_cr}) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL line_pix_values: got %0d bad pixels expected 0", bad); else passed++;
        for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 8'h80 : 8'h10);
        checks++; if (n_pv !== 720) $display("FAIL line_pix_count: got %0d expected 720", n_pv); else passed++;
        checks++; if (pix_cnt !== 11'd720) $display("FAIL line_pix_cnt: got %0d expected 720", pix_cnt); else passed++;
        send_trs(8'h9D);
        checks++; if (eav !== 1'b1 || pix_cnt !== 11'd0 || line_cnt !== 10'd3) $display("FAIL line_end_eav: got eav %b pix_cnt %0d line %0d expected 1 0 3", eav, pix_cnt, line_cnt); else passed++;
    endtask

    task automatic test_frame_start();
        send_trs(8'hF1);
        checks++; if ({eav, frame_start, f, v, h} !== 5'b10111 || line_cnt !== 10'd4) $display("FAIL field1_eav: got %b line %0d expected 10111 line 4", {eav, frame_start, f, v, h}, line_cnt); else passed++;
        send_trs(8'h9D);
        checks++; if ({eav, frame_start, f} !== 3'b110) $display("FAIL frame_start: got %b expected %b", {eav, frame_start, f}, 3'b110); else passed++;
        checks++; if (line_cnt !== 10'd0) $display("FAIL frame_line_clear: got %0d expected 0", line_cnt); else passed++;
        send(8'h10);
        checks++; if (frame_start !== 1'b0) $display("FAIL frame_start_one_cycle: got %b expected 0", frame_start); else passed++;
    endtask

    task automatic test_vblank();
        send_trs(8'hAB);
        checks++; if ({sav, f, v, h} !== 4'b1010) $display("FAIL vblank_sav: got %b expected %b", {sav, f, v, h}, 4'b1010); else passed++;
        clear_counts();
        send_group(8'h80, 8'h10, 8'h80, 8'h20);
        checks++; if (n_pv !== 0) $display("FAIL vblank_no_pix: got %0d expected 0", n_pv); else passed++;
    endtask

    task automatic test_din_en_gaps();
        logic [7:0] seq [13] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h9D, 8'hFF, 8'h00, 8'h00,
                                 8'h80, 8'h80, 8'h10, 8'h80, 8'h20};
        clear_counts();
        for (int i = 0; i < 13; i++) begin
            send(seq[i]);
            gap();
        end
        checks++; if (n_eav !== 1 || n_sav !== 1 || n_err !== 0) $display("FAIL gaps_strobes: got eav %0d sav %0d err %0d expected 1 1 0", n_eav, n_sav, n_err); else passed++;
        checks++; if (n_pv !== 2) $display("FAIL gaps_pix_count: got %0d expected 2", n_pv); else passed++;
        checks++; if ({pix_valid, y, cb, cr} !== {1'b0, 24'h208080}) $display("FAIL gaps_held: got %b %h expected 0 208080", pix_valid, {y, cb, cr}); else passed++;
        checks++; if (pix_cnt !== 11'd2 || line_cnt !== 10'd1) $display("FAIL gaps_cnts: got %0d/%0d expected 2/1", pix_cnt, line_cnt); else passed++;
    endtask

    task automatic test_reset_mid_line();
        send_trs(8'h9D);
        send_trs(8'h80);
        for (int i = 0; i < 50; i++) send_group(8'h44, 8'h55, 8'h66, 8'h77);
        checks++; if (pix_cnt !== 11'd100) $display("FAIL pre_reset_pix_cnt: got %0d expected 100", pix_cnt); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if ({y, cb, cr} !== 24'h0 || {f, v, h} !== 3'b011) $display("FAIL async_reset_vals: got %h %b expected 000000 011", {y, cb, cr}, {f, v, h}); else passed++;
        checks++; if (line_cnt !== 10'd0 || pix_cnt !== 11'd0) $display("FAIL async_reset_cnts: got %0d/%0d expected 0/0", line_cnt, pix_cnt); else passed++;
        #2 rst = 1'b0;
        clear_counts();
        for (int i = 0; i < 20; i++) send_group(8'h44, 8'h55, 8'h66, 8'h77);
        checks++; if (n_pv !== 0) $display("FAIL post_reset_no_pix: got %0d expected 0", n_pv); else passed++;
        send_trs(8'h80);
        checks++; if ({sav, f, v, h} !== 4'b1000) $display("FAIL post_reset_sav: got %b expected %b", {sav, f, v, h}, 4'b1000); else passed++;
        send_group(8'h44, 8'h55, 8'h66, 8'h77);
        checks++; if (n_pv !== 2 || {y, cb, cr} !== 24'h774466) $display("FAIL post_reset_pix: got %0d %h expected 2 774466", n_pv, {y, cb, cr}); else passed++;
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_basic_line();
        test_code_err();
        test_full_line();
        test_frame_start();
        test_vblank();
        test_din_en_gaps();
        test_reset_mid_line();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bt656_decoder.md
BT656_DECODER -- requirements
Module: bt656_decoder

Interface
REQ-001 SHALL have parameter ACTIVE_PIX, default 720, giving the number of active luma samples per line.
REQ-002 SHALL have parameter LINE_W, default 10, giving the width of line_cnt.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, 27 MHz byte clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port din_en, input, 1 bit: byte qualifier; din is sampled only when din_en=1.
REQ-006 SHALL have port din, input, 8 bits: BT.656 multiplexed Cb/Y/Cr/Y byte stream.
REQ-007 SHALL have ports y, cb and cr, outputs, 8 bits each: current pixel components.
REQ-008 SHALL have port pix_valid, output, 1 bit: one-cycle strobe, y/cb/cr valid.
REQ-009 SHALL have ports f, v and h, outputs, 1 bit each: last valid timing-code flags.
REQ-010 SHALL have ports sav and eav, outputs, 1 bit each: one-cycle strobes on a valid SAV or EAV.
REQ-011 SHALL have port frame_start, output, 1 bit: one-cycle strobe on an f 1->0 transition.
REQ-012 SHALL have port code_err, output, 1 bit: one-cycle strobe on a corrupt XY byte.
REQ-013 SHALL have port line_cnt, output, LINE_W bits: EAV count since frame_start.
REQ-014 SHALL have port pix_cnt, output, 11 bits: pixels emitted on the current line.

Function
REQ-015 SHALL run a sync detector with states IDLE, S_FF, S_00A, S_00B and S_XY, advancing only on din_en=1 bytes.
REQ-016 SHALL make these sync transitions:
- IDLE to S_FF on 0xFF.
- S_FF to S_00A on 0x00; S_FF stays in S_FF on 0xFF; S_FF returns to IDLE on any other byte.
- S_00A to S_00B on 0x00; S_00A goes to S_FF on 0xFF; S_00A returns to IDLE on any other byte.
- S_00B to S_XY unconditionally.
REQ-017 SHALL decode the XY byte as bit7=1, F=bit6, V=bit5, H=bit4, P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
REQ-018 SHALL treat bit7=0 or any parity mismatch as invalid, pulse code_err, and leave f, v, h and all counters unchanged.
REQ-019 SHALL, on a valid XY byte, update f/v/h and pulse eav when H=1 or sav when H=0, one cycle after the XY byte is sampled.
REQ-020 SHALL, on valid EAV, increment line_cnt (saturating at all-ones) and clear pix_cnt.
REQ-021 SHALL, on valid EAV with new F=0 and previous f=1, pulse frame_start and clear line_cnt to 0 instead of incrementing it.
REQ-022 SHALL enter active capture after a valid SAV with V=0; byte phase cycles Cb, Y0, Cr, Y1 starting at phase 0.
REQ-023 SHALL emit pixel A (y=Y0, cb, cr) with pix_valid on the Cr byte and pixel B (y=Y1, same cb/cr) on the Y1 byte, registered with 1-cycle latency.
REQ-024 SHALL increment pix_cnt once per pix_valid; capture SHALL stop when pix_cnt reaches ACTIVE_PIX, and further bytes up to the next EAV are ignored.
REQ-025 SHALL, on 0xFF during capture, end capture, emit no pixel for that byte, and let the sync detector take the byte.
REQ-026 SHALL not capture after an SAV with V=1 (vertical blanking); sav still pulses.
REQ-027 SHALL hold all outputs and state when din_en=0; strobes are low in such cycles.
REQ-028 SHALL pulse at most one of sav, eav and code_err in any cycle.

Reset
REQ-029 SHALL, while rst=1, asynchronously force sync state to IDLE, capture off and byte phase 0.
REQ-030 SHALL, while rst=1, force y, cb and cr to 0x00, f=0, v=1, h=1, all strobes low, and line_cnt=pix_cnt=0.
REQ-031 SHALL, after rst deasserts mid-line, emit no pixel until the next valid SAV.

Structure
REQ-032 SHALL place the timing-code constants (0xFF, 0x00), sync-state encodings and XY bit positions in a shared package video_pkg, for reuse by the BT.656 generator.
REQ-033 SHALL implement XY decode and parity check as sub-module bt656_xy_check (8-bit in; f, v, h, ok out; purely combinational); all other logic stays in bt656_decoder.

Verification
REQ-034 SHALL cover: FF 00 00 9D, then 80 10 80 20 -> eav=1 then sav=1, f=0 v=0 h=0, two pix_valid with y=10/20, cb=80, cr=80, pix_cnt=2.
REQ-035 SHALL cover: XY=0x9C (P0 flipped) -> code_err=1, no sav/eav, f/v/h unchanged.
REQ-036 SHALL cover: full line of 720 pixels plus 8 extra bytes before EAV -> exactly 720 pix_valid, then pix_cnt cleared on EAV.
REQ-037 SHALL cover: field 1 EAV (F=1) followed by field 0 EAV (XY=0xF1 then 0x9D) -> frame_start=1, line_cnt=0.
REQ-038 SHALL cover: FF FF 00 00 9D, plus din_en toggling every other cycle -> a single sav, identical output values.
REQ-039 SHALL cover: rst pulsed after 100 active pixels -> outputs return to reset values immediately; no pix_valid until the next SAV.
